// File: rtl/uart_defs.sv
// Shared UART definitions: default clocking, bit timing and FSM state encoding
// used by the transmitter and the future receiver.
package uart_defs;

    localparam int unsigned DEFAULT_CLK_FREQ = 32'd50000000;
    localparam int unsigned DEFAULT_BAUD     = 32'd500000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                                 input int unsigned baud);
        return clk_freq / baud;
    endfunction

    localparam int unsigned DEFAULT_CLKS_PER_BIT = clks_per_bit(DEFAULT_CLK_FREQ, DEFAULT_BAUD);

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy; a write when full is taken only
// if a read frees a slot on the same edge.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en_i,
    input  logic [WIDTH-1:0]         wr_data_i,
    input  logic                     rd_en_i,
    output logic [WIDTH-1:0]         rd_data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    count_q, count_d;
    logic             rd_ok_s;
    logic             wr_ok_s;

    assign full_o    = (count_q == LW'(DEPTH));
    assign empty_o   = (count_q == {LW{1'b0}});
    assign level_o   = count_q;
    assign rd_data_o = mem_q[rd_ptr_q];

    // Accept decisions and pointer/occupancy next state; pointers wrap naturally.
    always_comb begin
        rd_ok_s  = rd_en_i && !empty_o;
        wr_ok_s  = wr_en_i && (!full_o || rd_ok_s);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_ok_s) begin
            wr_ptr_d = wr_ptr_q + {{(AW-1){1'b0}}, 1'b1};
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (rd_ok_s) begin
            rd_ptr_d = rd_ptr_q + {{(AW-1){1'b0}}, 1'b1};
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({wr_ok_s, rd_ok_s})
            2'b10:   count_d = count_q + {{(LW-1){1'b0}}, 1'b1};
            2'b01:   count_d = count_q - {{(LW-1){1'b0}}, 1'b1};
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {LW{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage write; contents need no reset since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (wr_ok_s) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: processor stores are queued in a FIFO and
// shifted out LSB first; the AVR's busy line gates only the start of a frame.
module mmio_uart_tx
    import uart_defs::*;
#(
    parameter int unsigned CLK_FREQ   = DEFAULT_CLK_FREQ,
    parameter int unsigned BAUD       = DEFAULT_BAUD,
    parameter int unsigned FIFO_DEPTH = 32'd8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_en,
    input  logic [7:0]                    wr_data,
    output logic                          full,
    output logic                          idle,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          tx,
    input  logic                          tx_block
);

    localparam int unsigned CPB   = clks_per_bit(CLK_FREQ, BAUD);
    localparam int unsigned CNT_W = (CPB > 32'd1) ? $clog2(CPB) : 32'd1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CPB - 32'd1);

    uart_state_e      state_q, state_d;
    logic [CNT_W-1:0] baud_q, baud_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;
    logic             overflow_q, overflow_d;
    logic             sync1_q, sync2_q;

    logic             pop_s;
    logic             bit_done_s;
    logic             can_start_s;
    logic [7:0]       head_s;
    logic             fifo_full_s;
    logic             fifo_empty_s;
    logic [$clog2(FIFO_DEPTH):0] fifo_level_s;

    sync_fifo #(
        .WIDTH (32'd8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (wr_en),
        .wr_data_i (wr_data),
        .rd_en_i   (pop_s),
        .rd_data_o (head_s),
        .full_o    (fifo_full_s),
        .empty_o   (fifo_empty_s),
        .level_o   (fifo_level_s)
    );

    assign full     = fifo_full_s;
    assign level    = fifo_level_s;
    assign idle     = fifo_empty_s && (state_q == ST_IDLE);
    assign overflow = overflow_q;
    assign tx       = tx_q;

    // Two-flop synchroniser for the asynchronous busy line; resets to "blocked".
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= tx_block;
            sync2_q <= sync1_q;
        end
    end

    // Frame sequencing; STOP chains straight into START so queued frames abut.
    always_comb begin
        state_d     = state_q;
        baud_d      = baud_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        pop_s       = 1'b0;
        bit_done_s  = (baud_q == CNT_LAST);
        can_start_s = !fifo_empty_s && !sync2_q;
        case (state_q)
            ST_IDLE: begin
                if (can_start_s) begin
                    pop_s   = 1'b1;
                    shift_d = head_s;
                    baud_d  = {CNT_W{1'b0}};
                    state_d = ST_START;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (bit_done_s) begin
                    baud_d  = {CNT_W{1'b0}};
                    bit_d   = 3'd0;
                    state_d = ST_DATA;
                end else begin
                    baud_d  = baud_q + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            ST_DATA: begin
                if (bit_done_s) begin
                    baud_d  = {CNT_W{1'b0}};
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                    end
                end else begin
                    baud_d  = baud_q + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            ST_STOP: begin
                if (bit_done_s) begin
                    baud_d = {CNT_W{1'b0}};
                    if (can_start_s) begin
                        pop_s   = 1'b1;
                        shift_d = head_s;
                        state_d = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    baud_d = baud_q + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_d = ST_IDLE;
                baud_d  = {CNT_W{1'b0}};
                bit_d   = 3'd0;
            end
        endcase
    end

    // Line level follows the current state one edge later; overflow is sticky.
    always_comb begin
        case (state_q)
            ST_IDLE:  tx_d = 1'b1;
            ST_START: tx_d = 1'b0;
            ST_DATA:  tx_d = shift_q[0];
            ST_STOP:  tx_d = 1'b1;
            default:  tx_d = 1'b1;
        endcase
        overflow_d = overflow_q | (wr_en & fifo_full_s & ~pop_s);
    end

    // Transmitter state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            baud_q     <= {CNT_W{1'b0}};
            bit_q      <= 3'd0;
            shift_q    <= 8'd0;
            tx_q       <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            overflow_q <= overflow_d;
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Scoreboarded bench: written bytes are queued as expected frames and a serial
// line decoder independently reconstructs each frame from tx.
module tb_mmio_uart_tx;

    localparam int CPB   = 100;
    localparam int FRAME = 10 * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'd0;
    logic       tx_block = 1'b0;
    logic       full, idle, overflow, tx;
    logic [3:0] level;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int epoch = 0;
    int mon_frames = 0;
    logic [7:0] exp_q [$];
    logic [7:0] burst_q [$];
    int frame_starts [$];

    mmio_uart_tx dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .full     (full),
        .idle     (idle),
        .overflow (overflow),
        .level    (level),
        .tx       (tx),
        .tx_block (tx_block)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #(10 * 90000);
        $display("FAIL watchdog: simulation still running at cycle %0d, required finish earlier", cyc);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Serial decoder: samples each bit in its middle and scores the frame.
    initial begin
        int start;
        int ep;
        logic s_bit, p_bit;
        logic [7:0] b;
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (tx === 1'b0) begin
                start = cyc;
                ep = epoch;
                repeat (CPB / 2) @(negedge clk);
                s_bit = tx;
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = tx;
                end
                repeat (CPB) @(negedge clk);
                p_bit = tx;
                if (ep == epoch) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_frame: got byte 0x%0h expected no frame", b);
                    end else begin
                        e = exp_q.pop_front();
                        if (b !== e) begin
                            failures++;
                            $display("FAIL frame_data: got 0x%0h expected 0x%0h", b, e);
                        end
                    end
                    check("start_bit", {31'd0, s_bit}, 32'd0);
                    check("stop_bit", {31'd0, p_bit}, 32'd1);
                    frame_starts.push_back(start);
                    mon_frames++;
                end
            end
        end
    end

    task automatic send_burst();
        foreach (burst_q[i]) begin
            @(negedge clk);
            wr_en = 1'b1;
            wr_data = burst_q[i];
            exp_q.push_back(burst_q[i]);
        end
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic wait_frames(input int target, input int budget, input string name);
        int n = 0;
        while (mon_frames < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, mon_frames, target);
    endtask

    task automatic wait_tx_low(input int budget, input string name);
        int n = 0;
        while (tx !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, {31'd0, tx}, 32'd0);
    endtask

    task automatic count_low(input int ncyc, output int lows);
        lows = 0;
        repeat (ncyc) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
    endtask

    initial begin
        int base;
        int lows;
        int n;
        repeat (3) @(negedge clk);
        check("rst_tx", {31'd0, tx}, 32'd1);
        check("rst_level", {28'd0, level}, 32'd0);
        check("rst_full", {31'd0, full}, 32'd0);
        check("rst_idle", {31'd0, idle}, 32'd1);
        check("rst_overflow", {31'd0, overflow}, 32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // single byte latency and bit pattern
        base = mon_frames;
        burst_q = '{8'hA5};
        send_burst();
        check("a5_level", {28'd0, level}, 32'd1);
        check("a5_tx_e0", {31'd0, tx}, 32'd1);
        @(negedge clk);
        check("a5_tx_e1", {31'd0, tx}, 32'd1);
        @(negedge clk);
        check("a5_tx_e2", {31'd0, tx}, 32'd0);
        wait_frames(base + 1, FRAME + 100, "a5_frame");
        repeat (60) @(negedge clk);
        check("a5_idle", {31'd0, idle}, 32'd1);

        // back-to-back contiguous frames
        base = mon_frames;
        burst_q = '{8'h01, 8'h02, 8'h03};
        send_burst();
        check("b2b_level_peak", {28'd0, level}, 32'd2);
        wait_frames(base + 3, 3 * FRAME + 100, "b2b_frames");
        if (mon_frames == base + 3) begin
            check("b2b_gap1", frame_starts[base + 1] - frame_starts[base], FRAME);
            check("b2b_gap2", frame_starts[base + 2] - frame_starts[base + 1], FRAME);
        end
        repeat (60) @(negedge clk);

        // blocked fill with overflow
        base = mon_frames;
        tx_block = 1'b1;
        repeat (3) @(negedge clk);
        burst_q = '{};
        for (int i = 0; i < 9; i++) burst_q.push_back(8'($urandom));
        send_burst();
        void'(exp_q.pop_back());
        check("blk_level", {28'd0, level}, 32'd8);
        check("blk_full", {31'd0, full}, 32'd1);
        check("blk_overflow", {31'd0, overflow}, 32'd1);
        count_low(200, lows);
        check("blk_tx_high", lows, 0);
        tx_block = 1'b0;
        wait_frames(base + 8, 8 * FRAME + 200, "blk_frames");
        repeat (1500) @(negedge clk);
        check("blk_no_ninth", mon_frames, base + 8);
        check("blk_idle", {31'd0, idle}, 32'd1);
        check("blk_overflow_sticky", {31'd0, overflow}, 32'd1);

        // busy asserted mid-frame gates only the next start
        base = mon_frames;
        burst_q = '{8'h55, 8'hC3};
        send_burst();
        wait_tx_low(10, "mid_start");
        repeat (300) @(negedge clk);
        tx_block = 1'b1;
        wait_frames(base + 1, FRAME, "mid_frame");
        count_low(1500, lows);
        check("mid_held", lows, 0);
        check("mid_level", {28'd0, level}, 32'd1);
        tx_block = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_sync_e3", {31'd0, tx}, 32'd1);
        @(negedge clk);
        check("mid_sync_e4", {31'd0, tx}, 32'd0);
        wait_frames(base + 2, FRAME + 100, "mid_second");
        repeat (60) @(negedge clk);

        // reset mid-frame
        base = mon_frames;
        burst_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        send_burst();
        wait_tx_low(10, "rst_frame_start");
        repeat (450) @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        epoch++;
        @(negedge clk);
        check("mrst_tx", {31'd0, tx}, 32'd1);
        check("mrst_level", {28'd0, level}, 32'd0);
        check("mrst_overflow", {31'd0, overflow}, 32'd0);
        check("mrst_idle", {31'd0, idle}, 32'd1);
        rst = 1'b0;
        count_low(3000, lows);
        check("mrst_quiet", lows, 0);
        check("mrst_frames", mon_frames, base);

        // write on the pop edge while full
        base = mon_frames;
        tx_block = 1'b1;
        repeat (3) @(negedge clk);
        burst_q = '{};
        for (int i = 0; i < 8; i++) burst_q.push_back(8'($urandom));
        send_burst();
        check("pop_full_pre", {31'd0, full}, 32'd1);
        @(negedge clk);
        tx_block = 1'b0;
        @(negedge clk);
        @(negedge clk);
        wr_en = 1'b1;
        wr_data = 8'h7E;
        exp_q.push_back(8'h7E);
        @(negedge clk);
        wr_en = 1'b0;
        check("pop_level", {28'd0, level}, 32'd8);
        check("pop_full", {31'd0, full}, 32'd1);
        check("pop_overflow", {31'd0, overflow}, 32'd0);
        @(negedge clk);
        check("pop_tx_start", {31'd0, tx}, 32'd0);
        wait_frames(base + 9, 9 * FRAME + 200, "pop_frames");
        repeat (60) @(negedge clk);

        // randomized bursts from idle
        for (int k = 0; k < 4; k++) begin
            base = mon_frames;
            n = $urandom_range(1, 5);
            burst_q = '{};
            for (int i = 0; i < n; i++) burst_q.push_back(8'($urandom));
            send_burst();
            check("rnd_level", {28'd0, level}, (n == 1) ? 32'd1 : 32'(n - 1));
            wait_frames(base + n, n * FRAME + 200, "rnd_frames");
            repeat (60) @(negedge clk);
            check("rnd_idle", {31'd0, idle}, 32'd1);
            repeat ($urandom_range(1, 40)) @(negedge clk);
        end

        check("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
